and_gate_core: RTL and testbench
================================

AND_GATE_CORE -- requirements
Module: and_gate_core

Interface
REQ-001 Parameter: CNT_W, default 3, width of event counter and out_c1.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous reset, active-low.
REQ-004 Port: a  input  1  AND operand 0.
REQ-005 Port: c  input  1  AND operand 1.
REQ-006 Port: w  input  1  AND operand 2.
REQ-007 Port: data  input  2  auxiliary operand pair for dt.
REQ-008 Port: c_o  output  1  registered three-input AND result.
REQ-009 Port: dt  output  1  registered data-qualified AND result.
REQ-010 Port: out_c1  output  CNT_W  count of cycles in which a&c&w was 1.
REQ-011 Port: tc  output  1  terminal-count pulse on counter wrap.
REQ-012 The block SHALL have one clock, clk, and reset SHALL be asynchronous, active-low, on rst_n; polarity and synchronicity are fixed.

Function
REQ-013 Each rising clk edge SHALL load c_o <= a & c & w; latency exactly one cycle.
REQ-014 Each rising clk edge SHALL load dt <= a & data[1] & data[0]; latency exactly one cycle.
REQ-015 The counter SHALL increment by 1 on every rising edge where a & c & w == 1, and hold otherwise.
REQ-016 out_c1 SHALL present the counter register directly (no extra pipeline stage).
REQ-017 Counter SHALL wrap modulo 2^CNT_W: all-ones plus increment -> 0.
REQ-018 tc SHALL be 1 for exactly the one cycle following an edge at which the counter wrapped from all-ones to 0; otherwise 0.
REQ-019 No increment at all-ones SHALL leave the counter at all-ones with tc = 0.
REQ-020 Inputs are synchronous to clk; no internal synchronizers.
REQ-021 Any X/Z on inputs is outside contract; outputs SHALL never be driven combinationally from inputs.

Reset
REQ-022 While rst_n == 0, c_o, dt, tc SHALL be 0 and out_c1 SHALL be 0, asynchronously, regardless of clk.
REQ-023 Reset asserted mid-count SHALL discard the count; no increment or tc on the deasserting edge's cycle before the first active clk edge.
REQ-024 After rst_n rises, the first rising clk edge SHALL perform normal evaluation.

Structure
REQ-025 CNT_W default constant SHALL live in shared package and_gate_pkg.
REQ-026 Counter plus tc generation SHALL be one sub-module, and_gate_cnt (inputs clk, rst_n, inc; outputs count, tc).
REQ-027 Top-level SHALL contain only the c_o/dt registers and the and_gate_cnt instance.

Verification
REQ-028 Reset: rst_n=0 with a=c=w=1, data=11 for 3 edges -> c_o=dt=tc=0, out_c1=0.
REQ-029 Exhaustive sweep: {a,c,w,data} stepped 00000..11111, one per cycle -> c_o==1 only the cycle after 111xx, dt==1 only the cycle after 1xx11.
REQ-030 Counting: a=c=w=1 held 5 cycles from reset -> out_c1 = 1,2,3,4,5 on successive cycles.
REQ-031 Wrap: a=c=w=1 held 8 cycles from reset -> out_c1 goes 7 -> 0, tc=1 for exactly that one cycle, 0 before and after.
REQ-032 Hold: count=7, then w=0 for 3 cycles -> out_c1 stays 7, tc=0.
REQ-033 Async reset mid-count: count=4, rst_n pulled low between edges -> out_c1=0 immediately, no tc.

Source files
------------

// File: rtl/and_gate_pkg.sv
// Shared constants for the and_gate_core block and its event counter.
package and_gate_pkg;

   localparam int CNT_W_DEF = 3;

   function automatic logic all_ones(input logic [31:0] val, input int width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val & mask) == mask;
   endfunction

endpackage

// File: rtl/and_gate_cnt.sv
// Wrapping event counter with a one-cycle terminal-count pulse after wrap.
module and_gate_cnt
   import and_gate_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   logic at_max;
   assign at_max = (count == {CNT_W{1'b1}});

   // tc marks the cycle after the all-ones -> 0 transition only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         tc <= inc & at_max;
         if (inc) count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/and_gate_core.sv
// Registered three-input AND, data-qualified AND, and an event counter of AND hits.
module and_gate_core
   import and_gate_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             c,
   input  logic             w,
   input  logic [1:0]       data,
   output logic             c_o,
   output logic             dt,
   output logic [CNT_W-1:0] out_c1,
   output logic             tc
);

   logic hit;
   assign hit = a & c & w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_o <= 1'b0;
         dt  <= 1'b0;
      end else begin
         c_o <= hit;
         dt  <= a & data[1] & data[0];
      end
   end

   and_gate_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit),
      .count (out_c1),
      .tc    (tc)
   );

endmodule

// File: tb/tb_and_gate_core.sv
// Randomized scoreboard bench for and_gate_core against a behavioural model.
module tb_and_gate_core;

   localparam int CNT_W = 3;
   localparam int MODV  = 1 << CNT_W;

   typedef struct packed {
      logic             c_o;
      logic             dt;
      logic             tc;
      logic [CNT_W-1:0] cnt;
   } resp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             a = 1'b0, c = 1'b0, w = 1'b0;
   logic [1:0]       data = 2'b00;
   logic             c_o, dt, tc;
   logic [CNT_W-1:0] out_c1;

   int n_cmp = 0;
   int n_err = 0;
   int model_cnt = 0;
   resp_t exp_q[$];

   and_gate_core #(.CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .c      (c),
      .w      (w),
      .data   (data),
      .c_o    (c_o),
      .dt     (dt),
      .out_c1 (out_c1),
      .tc     (tc)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus at the falling edge and queue what the next rising edge must produce
   task automatic step(input logic r, input logic ia, input logic ic, input logic iw, input logic [1:0] id);
      resp_t e;
      int    nxt;
      @(negedge clk);
      rst_n = r; a = ia; c = ic; w = iw; data = id;
      if (!r) begin
         model_cnt = 0;
         e = '0;
      end else begin
         nxt       = model_cnt + ((ia && ic && iw) ? 1 : 0);
         e.c_o     = ia && ic && iw;
         e.dt      = ia && id[1] && id[0];
         e.tc      = (nxt == MODV);
         model_cnt = nxt % MODV;
         e.cnt     = CNT_W'(model_cnt);
      end
      exp_q.push_back(e);
   endtask

   // Monitor: every rising edge produces a response; compare it against the oldest expectation
   always @(posedge clk) begin
      resp_t got, e;
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = '{c_o: c_o, dt: dt, tc: tc, cnt: out_c1};
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL outputs t=%0t got c_o=%b dt=%b tc=%b cnt=%0d want c_o=%b dt=%b tc=%b cnt=%0d",
                     $time, got.c_o, got.dt, got.tc, got.cnt, e.c_o, e.dt, e.tc, e.cnt);
         end
      end
   end

   task automatic check_async(input string name);
      n_cmp++;
      if (out_c1 !== '0 || tc !== 1'b0 || c_o !== 1'b0 || dt !== 1'b0) begin
         n_err++;
         $display("FAIL %s got cnt=%0d tc=%b c_o=%b dt=%b want all zero", name, out_c1, tc, c_o, dt);
      end
   endtask

   initial begin
      logic [4:0] v;
      // Reset held with every operand high
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11);

      // Exhaustive operand sweep {a,c,w,data}
      for (int i = 0; i < 32; i++) begin
         v = 5'(i);
         step(1'b1, v[4], v[3], v[2], v[1:0]);
      end

      // Count 7 from reset, hold 3, wrap, then idle
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (7) step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
      repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
      step(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
      repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1, 2'b10);

      // Straight 8-cycle wrap from reset
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

      // Async reset between edges at count 4
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1 check_async("async_reset");
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
      step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11);

      // Random traffic, biased toward AND hits, with sparse resets
      for (int i = 0; i < 300; i++) begin
         logic r, ra, rc, rw;
         r  = ($urandom_range(0, 39) != 0);
         ra = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 3) != 0);
         rw = ($urandom_range(0, 3) != 0);
         step(r, ra, rc, rw, 2'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
